// File: rtl/mw_pkg.sv
// Shared constants for the microwave sequencing controller: FSM encodings and entry limits.
package mw_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_COOK  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_QLOAD = 3'd5;

    localparam logic [1:0] MAX_DIGITS   = 2'd3;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] MAX_BCD      = 4'd9;
endpackage

// File: rtl/microwave_controller_tick_gen.sv
// Count-down tick divider: one registered tick every TICK_DIV cycles of run; holds while run=0.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clearn,
    input  logic run,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (!clearn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (run) begin
                if (cnt_q == CW'(TICK_DIV - 1)) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/microwave_controller.sv
// Microwave sequencing FSM: keypad entry, start/pause/clear, 1 Hz tick, magnetron and beep.
// Optional quick-start (start in IDLE loads 00:30) enabled by `define MICROWAVE_QUICK_START_EN.
module microwave_controller
    import mw_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int BEEP_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clr,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_load,
    output logic       timer_enable,
    output logic       timer_clearn,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_o
);
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    logic [2:0]    state_q, state_d;
    logic [1:0]    digit_cnt_q, digit_cnt_d;
    logic [3:0]    sh_min_q, sh_min_d, sh_st_q, sh_st_d, sh_so_q, sh_so_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic [3:0]    timer_data_q, timer_data_d;
    logic          timer_load_q, timer_load_d;
    logic          timer_clearn_q, timer_clearn_d;
    logic          mag_on_q, beep_q;
    logic          key_ok, start_ok, cook_entry, tick_run, tick;
`ifdef MICROWAVE_QUICK_START_EN
    logic          qphase_q, qphase_d;
`endif

    assign key_ok   = key_valid && (key_digit <= MAX_BCD);
    assign start_ok = start && door_closed && ({sh_min_q, sh_st_q, sh_so_q} != 12'd0)
                      && (sh_st_q <= MAX_SEC_TENS);

    always_comb begin
        state_d        = state_q;
        digit_cnt_d    = digit_cnt_q;
        sh_min_d       = sh_min_q;
        sh_st_d        = sh_st_q;
        sh_so_d        = sh_so_q;
        beep_cnt_d     = beep_cnt_q;
        timer_data_d   = timer_data_q;
        timer_load_d   = 1'b0;
        timer_clearn_d = 1'b1;
`ifdef MICROWAVE_QUICK_START_EN
        qphase_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MICROWAVE_QUICK_START_EN
                if (start && door_closed) begin
                    state_d      = ST_QLOAD;
                    timer_load_d = 1'b1;
                    timer_data_d = 4'd3;
                    {sh_min_d, sh_st_d, sh_so_d} = {sh_st_q, sh_so_q, 4'd3};
                    digit_cnt_d  = 2'd1;
                end else
`endif
                if (key_ok) begin
                    state_d      = ST_ENTRY;
                    timer_load_d = 1'b1;
                    timer_data_d = key_digit;
                    {sh_min_d, sh_st_d, sh_so_d} = {sh_st_q, sh_so_q, key_digit};
                    digit_cnt_d  = 2'd1;
                end
            end
            ST_ENTRY: begin
                // A start strobe always swallows a coincident key, even if the start is rejected.
                if (start_ok) begin
                    state_d = ST_COOK;
                end else if (stop_clr) begin
                    state_d        = ST_IDLE;
                    timer_clearn_d = 1'b0;
                    digit_cnt_d    = 2'd0;
                    {sh_min_d, sh_st_d, sh_so_d} = 12'd0;
                end else if (key_ok && !start && (digit_cnt_q < MAX_DIGITS)) begin
                    timer_load_d = 1'b1;
                    timer_data_d = key_digit;
                    {sh_min_d, sh_st_d, sh_so_d} = {sh_st_q, sh_so_q, key_digit};
                    digit_cnt_d  = digit_cnt_q + 2'd1;
                end
            end
            ST_COOK: begin
                if (timer_zero) begin
                    state_d    = ST_DONE;
                    beep_cnt_d = '0;
                end else if (!door_closed || stop_clr) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop_clr) begin
                    state_d        = ST_IDLE;
                    timer_clearn_d = 1'b0;
                    digit_cnt_d    = 2'd0;
                    {sh_min_d, sh_st_d, sh_so_d} = 12'd0;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_clr || (beep_cnt_q == BW'(BEEP_CYCLES - 1))) begin
                    state_d     = ST_IDLE;
                    digit_cnt_d = 2'd0;
                    {sh_min_d, sh_st_d, sh_so_d} = 12'd0;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
`ifdef MICROWAVE_QUICK_START_EN
            ST_QLOAD: begin
                if (!qphase_q) begin
                    qphase_d     = 1'b1;
                    timer_load_d = 1'b1;
                    timer_data_d = 4'd0;
                    {sh_min_d, sh_st_d, sh_so_d} = {sh_st_q, sh_so_q, 4'd0};
                    digit_cnt_d  = 2'd2;
                end else begin
                    state_d = ST_COOK;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Tick divider restarts from zero on each COOK entry and only runs while COOK persists.
    assign cook_entry = (state_d == ST_COOK) && (state_q != ST_COOK);
    assign tick_run   = (state_q == ST_COOK) && (state_d == ST_COOK);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .clearn (clearn && !cook_entry),
        .run    (tick_run),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q        <= ST_IDLE;
            digit_cnt_q    <= 2'd0;
            sh_min_q       <= 4'd0;
            sh_st_q        <= 4'd0;
            sh_so_q        <= 4'd0;
            beep_cnt_q     <= '0;
            timer_data_q   <= 4'd0;
            timer_load_q   <= 1'b0;
            timer_clearn_q <= 1'b0;
            mag_on_q       <= 1'b0;
            beep_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            digit_cnt_q    <= digit_cnt_d;
            sh_min_q       <= sh_min_d;
            sh_st_q        <= sh_st_d;
            sh_so_q        <= sh_so_d;
            beep_cnt_q     <= beep_cnt_d;
            timer_data_q   <= timer_data_d;
            timer_load_q   <= timer_load_d;
            timer_clearn_q <= timer_clearn_d;
            mag_on_q       <= (state_d == ST_COOK);
            beep_q         <= (state_d == ST_DONE);
        end
    end

`ifdef MICROWAVE_QUICK_START_EN
    always_ff @(posedge clk) begin
        if (!clearn) qphase_q <= 1'b0;
        else         qphase_q <= qphase_d;
    end
`endif

    assign timer_data   = timer_data_q;
    assign timer_load   = timer_load_q;
    assign timer_enable = tick;
    assign timer_clearn = timer_clearn_q;
    assign mag_on       = mag_on_q;
    assign beep         = beep_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with TICK_DIV=4 and BEEP_CYCLES=8.
module tb_microwave_controller;
    logic       clk = 1'b0;
    logic       clearn, key_valid, start, stop_clr, door_closed, timer_zero;
    logic [3:0] key_digit;
    logic [3:0] timer_data;
    logic       timer_load, timer_enable, timer_clearn, mag_on, beep;
    logic [2:0] state_o;
    int         total = 0;
    int         bad   = 0;

    microwave_controller #(.TICK_DIV(4), .BEEP_CYCLES(8)) dut (
        .clk          (clk),
        .clearn       (clearn),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop_clr     (stop_clr),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .timer_data   (timer_data),
        .timer_load   (timer_load),
        .timer_enable (timer_enable),
        .timer_clearn (timer_clearn),
        .mag_on       (mag_on),
        .beep         (beep),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
    endtask

    initial begin
        clearn = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
        stop_clr = 1'b0; door_closed = 1'b0; timer_zero = 1'b0;
        cyc(); cyc();
        chk("rst_state", state_o, 0);
        chk("rst_tclr", timer_clearn, 0);
        chk("rst_mag", mag_on, 0);
        chk("rst_beep", beep, 0);
        chk("rst_load", timer_load, 0);
        chk("rst_en", timer_enable, 0);
        chk("rst_data", timer_data, 0);
        clearn = 1'b1;
        cyc();
        chk("tclr_release", timer_clearn, 1);

        // Non-BCD key is ignored in IDLE
        key(4'hA);
        chk("badkey_load", timer_load, 0);
        chk("badkey_state", state_o, 0);

        door_closed = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
`ifdef MICROWAVE_QUICK_START_EN
        chk("qs_state", state_o, 5);
        chk("qs_load0", timer_load, 1);
        chk("qs_data0", timer_data, 3);
        cyc();
        chk("qs_load1", timer_load, 1);
        chk("qs_data1", timer_data, 0);
        cyc();
        chk("qs_cook", state_o, 2);
        chk("qs_mag", mag_on, 1);
        chk("qs_load2", timer_load, 0);
        clearn = 1'b0; cyc(); clearn = 1'b1; cyc();
`else
        chk("idle_start_state", state_o, 0);
        chk("idle_start_load", timer_load, 0);
`endif

        // Keys 1,3,0 then start
        key(4'd1);
        chk("k1_load", timer_load, 1);
        chk("k1_data", timer_data, 1);
        chk("k1_state", state_o, 1);
        key(4'd3);
        chk("k3_load", timer_load, 1);
        chk("k3_data", timer_data, 3);
        key(4'd0);
        chk("k0_load", timer_load, 1);
        chk("k0_data", timer_data, 0);
        cyc();
        chk("load_drop", timer_load, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("cook_state", state_o, 2);
        chk("cook_mag", mag_on, 1);
        chk("cook_en0", timer_enable, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("cook_tick", timer_enable, (i % 4 == 0) ? 1 : 0);
        end

        // Door open pauses; no ticks while paused
        door_closed = 1'b0; cyc();
        chk("pause_state", state_o, 3);
        chk("pause_mag", mag_on, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("pause_tick", timer_enable, 0);
        end
        door_closed = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        chk("resume_state", state_o, 2);
        chk("resume_mag", mag_on, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("resume_tick", timer_enable, (i == 4) ? 1 : 0);
        end

        // timer_zero beats door open and stop_clr
        timer_zero = 1'b1; stop_clr = 1'b1; door_closed = 1'b0; cyc();
        timer_zero = 1'b0; stop_clr = 1'b0; door_closed = 1'b1;
        chk("done_state", state_o, 4);
        chk("done_beep", beep, 1);
        chk("done_mag", mag_on, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("beep_hold", beep, (i < 8) ? 1 : 0);
            chk("beep_state", state_o, (i < 8) ? 4 : 0);
        end

        // Fourth digit ignored
        key(4'd1); key(4'd2);
        chk("k2_data", timer_data, 2);
        key(4'd3);
        chk("k3b_load", timer_load, 1);
        key(4'd4);
        chk("k4_load", timer_load, 0);
        chk("k4_data", timer_data, 3);
        chk("k4_state", state_o, 1);
        door_closed = 1'b0; start = 1'b1; cyc(); start = 1'b0; door_closed = 1'b1;
        chk("dooropen_start", state_o, 1);
        chk("dooropen_mag", mag_on, 0);
        stop_clr = 1'b1; cyc(); stop_clr = 1'b0;
        chk("entry_clr_tclr", timer_clearn, 0);
        chk("entry_clr_state", state_o, 0);
        cyc();
        chk("entry_clr_release", timer_clearn, 1);

        // Seconds-tens of 7 rejects start
        key(4'd0); key(4'd7); key(4'd0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("st7_state", state_o, 1);
        chk("st7_mag", mag_on, 0);
        stop_clr = 1'b1; cyc(); stop_clr = 1'b0;
        chk("st7_clr", state_o, 0);

        // All-zero entry rejects start; start beats a coincident key
        key(4'd0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("zero_start", state_o, 1);
        key(4'd2);
        key_valid = 1'b1; key_digit = 4'd9; start = 1'b1; cyc();
        key_valid = 1'b0; start = 1'b0;
        chk("keystart_state", state_o, 2);
        chk("keystart_load", timer_load, 0);
        chk("keystart_data", timer_data, 2);

        // stop_clr in COOK pauses, keys ignored, second stop_clr clears
        stop_clr = 1'b1; cyc(); stop_clr = 1'b0;
        chk("stop_pause", state_o, 3);
        chk("stop_pause_mag", mag_on, 0);
        key(4'd5);
        chk("pause_key_load", timer_load, 0);
        chk("pause_key_state", state_o, 3);
        stop_clr = 1'b1; cyc(); stop_clr = 1'b0;
        chk("pause_clr_state", state_o, 0);
        chk("pause_clr_tclr", timer_clearn, 0);
        cyc();
        chk("pause_clr_release", timer_clearn, 1);

        // Reset in the middle of COOK
        key(4'd4);
        start = 1'b1; cyc(); start = 1'b0;
        chk("pre_rst_cook", state_o, 2);
        cyc();
        clearn = 1'b0; cyc();
        chk("midrst_state", state_o, 0);
        chk("midrst_mag", mag_on, 0);
        chk("midrst_tclr", timer_clearn, 0);
        chk("midrst_en", timer_enable, 0);
        clearn = 1'b1; cyc();

        // stop_clr ends the beep early
        key(4'd1);
        start = 1'b1; cyc(); start = 1'b0;
        timer_zero = 1'b1; cyc(); timer_zero = 1'b0;
        chk("early_done", state_o, 4);
        cyc();
        stop_clr = 1'b1; cyc(); stop_clr = 1'b0;
        chk("early_state", state_o, 0);
        chk("early_beep", beep, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
